demux_stream_1ton: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer for the RISC-V datapath. It replaces the combinational 16-bit 1:2 demux with a clocked block: a valid/ready handshake on the input, a one-entry holding register per output channel, and an optional broadcast mode. Every output has a defined value on every cycle, so no latches are inferred. It sits between a single producer (e.g. the writeback or bus-response path) and N independent consumers, each with its own back-pressure.

---
 rtl/demux_stream_1ton.sv | 90 +++++++++
 tb/tb_demux_stream_1ton.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with a one-entry slot per channel.
// Supports a broadcast mode, and sinks unicasts to a nonexistent channel while counting them.
module demux_stream_1ton #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      drop_pulse,
    output logic [7:0]                drop_cnt
);

    logic [CHANNELS-1:0][WIDTH-1:0] data_q;
    logic [CHANNELS-1:0]            valid_q;
    logic [CHANNELS-1:0]            free;
    logic [CHANNELS-1:0]            load;
    logic                           sel_hit;
    logic                           sel_free;
    logic                           accept;
    logic                           drop;

    // A full slot that drains this cycle can take a new word (full-rate pass-through).
    assign free = ~valid_q | out_ready;

    always_comb begin
        sel_hit  = 1'b0;
        sel_free = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_hit  = 1'b1;
                sel_free = free[k];
            end
        end
    end

    always_comb begin
        if (in_bcast)
            in_ready = &free;
        else if (sel_hit)
            in_ready = sel_free;
        else
            in_ready = 1'b1;
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_hit;

    always_comb begin
        load = '0;
        for (int k = 0; k < CHANNELS; k++)
            load[k] = accept & (in_bcast | (in_sel == SEL_W'(k)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k])
                    data_q[k] <= in_data;
                valid_q[k] <= load[k] | (valid_q[k] & ~out_ready[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: a 4-channel instance for the main data path and a
// 3-channel instance for out-of-range drop counting, checked against a slot model.
module tb_demux_stream_1ton;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_in_data  = '0;
    logic [1:0]  a_in_sel   = '0;
    logic        a_in_bcast = 1'b0;
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [63:0] a_out_data;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready = 4'hF;
    logic        a_drop_pulse;
    logic [7:0]  a_drop_cnt;

    logic [15:0] b_in_data  = '0;
    logic [1:0]  b_in_sel   = '0;
    logic        b_in_bcast = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [47:0] b_out_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready = 3'b111;
    logic        b_drop_pulse;
    logic [7:0]  b_drop_cnt;

    demux_stream_1ton #(.WIDTH(16), .CHANNELS(4)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_bcast(a_in_bcast), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .drop_pulse(a_drop_pulse), .drop_cnt(a_drop_cnt)
    );

    demux_stream_1ton #(.WIDTH(16), .CHANNELS(3)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_bcast(b_in_bcast), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .drop_pulse(b_drop_pulse), .drop_cnt(b_drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the 4-channel instance: one slot per consumer.
    bit          m_valid [4];
    logic [15:0] m_data  [4];
    bit          last_acc;
    int          seen_1111;

    function automatic bit a_free(int k);
        return !m_valid[k] || a_out_ready[k];
    endfunction

    function automatic bit a_exp_ready();
        if (a_in_bcast)
            return a_free(0) && a_free(1) && a_free(2) && a_free(3);
        return a_free(int'(a_in_sel));
    endfunction

    function automatic logic [3:0] m_valid_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [63:0] m_data_vec();
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = m_data[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 16'h0000;
        end
    endtask

    // Advance one clock on instance A; inputs change only at posedge+1.
    task automatic a_tick();
        bit         acc;
        logic [3:0] drn;
        acc = a_in_valid && a_exp_ready();
        for (int k = 0; k < 4; k++) drn[k] = m_valid[k] && a_out_ready[k];
        if (a_out_valid[0] && a_out_ready[0] && a_out_data[15:0] == 16'h1111)
            seen_1111++;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (acc && (a_in_bcast || int'(a_in_sel) == k)) begin
                m_valid[k] = 1'b1;
                m_data[k]  = a_in_data;
            end else if (drn[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic a_idle(int n);
        a_in_valid  = 1'b0;
        a_in_bcast  = 1'b0;
        a_out_ready = 4'hF;
        for (int i = 0; i < n; i++) a_tick();
    endtask

    // Held-input rule while stalled, sampled on the falling edge.
    logic        stall_q = 1'b0;
    logic [15:0] hold_d;
    logic [1:0]  hold_s;
    logic        hold_b;
    always @(negedge clk) begin
        if (!rst && stall_q)
            assert (a_in_valid && a_in_data == hold_d && a_in_sel == hold_s && a_in_bcast == hold_b)
                else $error("input changed while stalled");
        stall_q <= !rst && a_in_valid && !a_in_ready;
        hold_d  <= a_in_data;
        hold_s  <= a_in_sel;
        hold_b  <= a_in_bcast;
    end

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (a_out_valid !== 4'h0 || a_out_data !== 64'h0) begin
            n_err++;
            $display("FAIL reset_slots: valid=%h data=%h want 0/0", a_out_valid, a_out_data);
        end
        n_cmp++;
        if (a_drop_cnt !== 8'd0 || a_drop_pulse !== 1'b0 || b_drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_drop: a_cnt=%0d a_pulse=%b b_cnt=%0d want 0", a_drop_cnt, a_drop_pulse, b_drop_cnt);
        end
        a_in_bcast = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_bcast: got %b want 1", a_in_ready);
        end
        a_in_bcast = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_unicast();
        a_out_ready = 4'hF;
        a_in_data   = 16'hA5A5;
        a_in_sel    = 2'd1;
        a_in_valid  = 1'b1;
        a_tick();
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_out_valid !== 4'b0010) begin
            n_err++;
            $display("FAIL uni_valid: got %b want 0010", a_out_valid);
        end
        n_cmp++;
        if (a_out_data[31:16] !== 16'hA5A5 || a_out_data[15:0] !== 16'h0000) begin
            n_err++;
            $display("FAIL uni_data: ch1=%h ch0=%h want a5a5/0000", a_out_data[31:16], a_out_data[15:0]);
        end
        a_idle(2);
    endtask

    task automatic test_backpressure();
        seen_1111   = 0;
        a_out_ready = 4'b1110;
        a_in_data   = 16'h1111;
        a_in_sel    = 2'd0;
        a_in_valid  = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first_ready: got %b want 1", a_in_ready);
        end
        a_tick();
        a_in_data = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (a_in_ready !== 1'b0 || a_out_data[15:0] !== 16'h1111 || a_out_valid[0] !== 1'b1) begin
                n_err++;
                $display("FAIL bp_stall: ready=%b v0=%b d0=%h want 0/1/1111", a_in_ready, a_out_valid[0], a_out_data[15:0]);
            end
            a_tick();
        end
        a_out_ready = 4'hF;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 1", a_in_ready);
        end
        a_tick();
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_out_valid[0] !== 1'b1 || a_out_data[15:0] !== 16'h2222) begin
            n_err++;
            $display("FAIL bp_no_bubble: v0=%b d0=%h want 1/2222", a_out_valid[0], a_out_data[15:0]);
        end
        a_idle(2);
        n_cmp++;
        if (seen_1111 != 1) begin
            n_err++;
            $display("FAIL bp_once: 1111 seen %0d times want 1", seen_1111);
        end
    endtask

    task automatic test_independent();
        a_out_ready = 4'b1011;
        a_in_data   = 16'h0002;
        a_in_sel    = 2'd2;
        a_in_valid  = 1'b1;
        a_tick();
        a_in_data = 16'h0003;
        a_in_sel  = 2'd3;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL indep_sel3_ready: got %b want 1", a_in_ready);
        end
        a_tick();
        a_in_data = 16'h0001;
        a_in_sel  = 2'd1;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL indep_sel1_ready: got %b want 1", a_in_ready);
        end
        a_tick();
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_out_valid !== 4'b0110 || a_out_data[47:32] !== 16'h0002 || a_out_data[31:16] !== 16'h0001) begin
            n_err++;
            $display("FAIL indep_state: valid=%b d2=%h d1=%h want 0110/0002/0001", a_out_valid, a_out_data[47:32], a_out_data[31:16]);
        end
        a_idle(2);
    endtask

    task automatic test_broadcast();
        a_out_ready = 4'b1110;
        a_in_data   = 16'h0C0C;
        a_in_sel    = 2'd0;
        a_in_valid  = 1'b1;
        a_tick();
        a_in_data  = 16'hBEEF;
        a_in_bcast = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 4'b0001 || a_out_data !== 64'h0000_0000_0000_0C0C &&
                a_out_data[15:0] !== 16'h0C0C) begin
                n_err++;
                $display("FAIL bcast_atomic: ready=%b valid=%b d0=%h want 0/0001/0c0c", a_in_ready, a_out_valid, a_out_data[15:0]);
            end
            n_cmp++;
            if (a_out_data !== m_data_vec()) begin
                n_err++;
                $display("FAIL bcast_hold_data: got %h want %h", a_out_data, m_data_vec());
            end
            a_tick();
        end
        a_out_ready = 4'hF;
        a_tick();
        a_in_valid = 1'b0;
        a_in_bcast = 1'b0;
        n_cmp++;
        if (a_out_valid !== 4'hF || a_out_data !== {4{16'hBEEF}}) begin
            n_err++;
            $display("FAIL bcast_all: valid=%b data=%h want f/beef x4", a_out_valid, a_out_data);
        end
        a_idle(2);
    endtask

    task automatic test_random();
        int bad = 0;
        last_acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(a_in_valid && !last_acc)) begin
                a_in_valid = ($urandom_range(0, 3) != 0);
                a_in_data  = 16'($urandom);
                a_in_sel   = 2'($urandom_range(0, 3));
                a_in_bcast = ($urandom_range(0, 5) == 0);
            end
            a_out_ready = 4'($urandom);
            #1;
            n_cmp++;
            if (a_in_ready !== a_exp_ready() || a_out_valid !== m_valid_vec() || a_out_data !== m_data_vec()) begin
                n_err++;
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_cycle%0d: ready=%b valid=%b data=%h want %b/%b/%h", i, a_in_ready,
                             a_out_valid, a_out_data, a_exp_ready(), m_valid_vec(), m_data_vec());
            end
            a_tick();
        end
        a_idle(2);
    endtask

    task automatic test_drop();
        bit       exp_pulse = 1'b0;
        int       exp_cnt   = 0;
        int       bad       = 0;
        b_in_sel   = 2'd3;
        b_in_bcast = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            b_in_data   = 16'($urandom);
            b_out_ready = 3'($urandom);
            #1;
            n_cmp++;
            if (b_in_ready !== 1'b1 || b_out_valid !== 3'b000 || b_drop_pulse !== exp_pulse ||
                b_drop_cnt !== 8'(exp_cnt)) begin
                n_err++;
                bad++;
                if (bad <= 5)
                    $display("FAIL drop_cycle%0d: ready=%b valid=%b pulse=%b cnt=%0d want 1/000/%b/%0d", i,
                             b_in_ready, b_out_valid, b_drop_pulse, b_drop_cnt, exp_pulse, exp_cnt);
            end
            @(posedge clk);
            exp_pulse = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
            #1;
        end
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (b_drop_cnt !== 8'd255 || b_drop_pulse !== 1'b0 || b_out_valid !== 3'b000) begin
            n_err++;
            $display("FAIL drop_final: cnt=%0d pulse=%b valid=%b want 255/0/000", b_drop_cnt, b_drop_pulse, b_out_valid);
        end
    endtask

    task automatic test_async_reset();
        a_out_ready = 4'h0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'h5A5A;
        a_in_sel    = 2'd0;
        a_tick();
        a_in_data = 16'h3C3C;
        a_in_sel  = 2'd2;
        a_tick();
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_out_valid !== 4'b0101) begin
            n_err++;
            $display("FAIL arst_setup: valid=%b want 0101", a_out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_out_valid !== 4'h0 || a_out_data !== 64'h0 || b_drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL arst_clear: valid=%b data=%h b_cnt=%0d want 0/0/0", a_out_valid, a_out_data, b_drop_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unicast();
        test_backpressure();
        test_independent();
        test_broadcast();
        test_random();
        test_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
